// File: rtl/guess_sequencer.sv
// guess_sequencer: sits between the PS/2 byte receiver and the scancode-to-letter
// decoder. Strips F0/E0 prefixes, drops typematic repeats, classifies the
// decoder result and offers fresh letter guesses to the game FSM.
// Optional feature macro: DUP_FILTER_EN (used-letter mask and dup_pulse).
module guess_sequencer #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    output logic [7:0]  dec_code,
    input  logic [4:0]  dec_letter,
    input  logic        clear_used,
    output logic        guess_valid,
    output logic [4:0]  guess_letter,
    input  logic        guess_ready,
    output logic        enter_pulse,
    output logic        dup_pulse,
    output logic [25:0] used_mask,
    output logic        busy
);

    localparam logic [7:0] BRK_CODE   = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [4:0] ENTER_CODE = 5'd26;
    localparam logic [4:0] LAST_LTR   = 5'd25;
    localparam bit         TMO_EN     = (ACK_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        GOT_F0,
        GOT_E0,
        GOT_E0F0,
        LOOKUP,
        OFFER
    } state_t;

    state_t           state;
    logic [7:0]       held_code;
    logic             brk_seen;
    logic [CNT_W-1:0] cnt;
    logic             is_dup;
    logic             accept;

    assign busy   = (state == LOOKUP) || (state == OFFER);
    assign accept = (state == OFFER) && guess_ready;

`ifdef DUP_FILTER_EN
    logic [25:0] mask_q;
    logic [31:0] mask_ext;
    logic [31:0] set_bit;

    assign mask_ext  = {6'b0, mask_q};
    assign set_bit   = 32'd1 << guess_letter;
    assign is_dup    = mask_ext[dec_letter];
    assign used_mask = mask_q;

    // Used-letter mask: a new-round clear overrides a coincident accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else if (clear_used) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= mask_q | set_bit[25:0];
        end
    end
`else
    logic unused_clear;

    assign unused_clear = clear_used;
    assign is_dup       = 1'b0;
    assign used_mask    = '0;
    assign dup_pulse    = 1'b0;
`endif

    // Main sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses <=; reads see the pre-edge values, which the
        // byte-filter and transition logic below rely on within one cycle.
        if (reset) begin
            state        <= IDLE;
            held_code    <= 8'h00;
            brk_seen     <= 1'b0;
            cnt          <= '0;
            dec_code     <= 8'h00;
            guess_valid  <= 1'b0;
            guess_letter <= 5'd0;
            enter_pulse  <= 1'b0;
`ifdef DUP_FILTER_EN
            dup_pulse    <= 1'b0;
`endif
        end else begin
            enter_pulse <= 1'b0;
`ifdef DUP_FILTER_EN
            dup_pulse   <= 1'b0;
`endif
            // While busy, only watch for the release of the held key.
            if (busy && scan_valid) begin
                if (brk_seen) begin
                    brk_seen <= 1'b0;
                    if (scan_code == held_code) held_code <= 8'h00;
                end else if (scan_code == BRK_CODE) begin
                    brk_seen <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (scan_valid) begin
                        if (scan_code == BRK_CODE) begin
                            state <= GOT_F0;
                        end else if (scan_code == EXT_CODE) begin
                            state <= GOT_E0;
                        end else if (scan_code == held_code && held_code != 8'h00) begin
                            state <= IDLE;
                        end else begin
                            dec_code  <= scan_code;
                            held_code <= scan_code;
                            state     <= LOOKUP;
                        end
                    end
                end
                GOT_F0: begin
                    if (scan_valid) begin
                        if (scan_code == held_code) held_code <= 8'h00;
                        state <= IDLE;
                    end
                end
                GOT_E0: begin
                    if (scan_valid) state <= (scan_code == BRK_CODE) ? GOT_E0F0 : IDLE;
                end
                GOT_E0F0: begin
                    if (scan_valid) state <= IDLE;
                end
                LOOKUP: begin
                    state    <= IDLE;
                    brk_seen <= 1'b0;
                    if (dec_letter == ENTER_CODE) begin
                        enter_pulse <= 1'b1;
                    end else if (dec_letter <= LAST_LTR) begin
                        if (is_dup) begin
`ifdef DUP_FILTER_EN
                            dup_pulse <= 1'b1;
`endif
                        end else begin
                            guess_letter <= dec_letter;
                            guess_valid  <= 1'b1;
                            cnt          <= '0;
                            state        <= OFFER;
                            brk_seen     <= brk_seen;
                        end
                    end
                end
                OFFER: begin
                    if (guess_ready || (TMO_EN && cnt == TMO_LAST)) begin
                        guess_valid <= 1'b0;
                        brk_seen    <= 1'b0;
                        state       <= IDLE;
                    end else if (TMO_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
